// File: rtl/accel_job_ctrl.sv
// DMA job controller: splits a read then a write transfer into burst-aligned commands.
// Optional wait-state watchdog enabled by defining ACCEL_JOB_TIMEOUT_EN.
module accel_job_ctrl #(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_BURST_BYTES     = 4096,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                    I_aclk,
    input  logic                    I_arst,
    input  logic                    I_start,
    input  logic [C_ADDR_WIDTH-1:0] I_ddr_rd_addr,
    input  logic [C_ADDR_WIDTH-1:0] I_ddr_wr_addr,
    input  logic [31:0]             I_in_data_bytes,
    input  logic [31:0]             I_out_data_bytes,
    output logic                    O_ap_start_done,
    output logic                    O_ap_ready,
    output logic                    O_ap_done,
    output logic                    O_rd_cmd_valid,
    input  logic                    I_rd_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] O_rd_cmd_addr,
    output logic [31:0]             O_rd_cmd_len,
    input  logic                    I_rd_cmd_done,
    output logic                    O_wr_cmd_valid,
    input  logic                    I_wr_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] O_wr_cmd_addr,
    output logic [31:0]             O_wr_cmd_len,
    input  logic                    I_wr_cmd_done,
    output logic                    O_err
);

    localparam int BB_LOG2 = $clog2(C_BURST_BYTES);
    localparam int OW      = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE} state_t;

    // Largest command that fits in rem without crossing the next burst boundary.
    function automatic logic [31:0] cmd_len(input logic [BB_LOG2-1:0] off, input logic [31:0] rem);
        logic [31:0] room;
        room = 32'(C_BURST_BYTES) - {{(32-BB_LOG2){1'b0}}, off};
        return (rem < room) ? rem : room;
    endfunction

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [31:0]             rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
    logic [OW-1:0]           out_q, out_d;
    logic                    rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
    logic [C_ADDR_WIDTH-1:0] rd_cmd_addr_q, rd_cmd_addr_d, wr_cmd_addr_q, wr_cmd_addr_d;
    logic [31:0]             rd_cmd_len_q, rd_cmd_len_d, wr_cmd_len_q, wr_cmd_len_d;
    logic                    start_done_q, start_done_d, ap_ready_q, ap_ready_d;
    logic                    ap_done_q, ap_done_d, err_q, err_d;
`ifdef ACCEL_JOB_TIMEOUT_EN
    logic [23:0]             to_cnt_q, to_cnt_d;
`endif

    logic rd_hs, wr_hs, rd_phase, wr_phase, rd_dn, wr_dn, bad_dn;

    always_comb begin
        rd_hs    = rd_valid_q && I_rd_cmd_ready;
        wr_hs    = wr_valid_q && I_wr_cmd_ready;
        rd_phase = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
        wr_phase = (state_q == WR_ISSUE) || (state_q == WR_WAIT);
        rd_dn    = I_rd_cmd_done && rd_phase && (out_q != '0);
        wr_dn    = I_wr_cmd_done && wr_phase && (out_q != '0);
        // A done that matches no outstanding command of the active phase is an error.
        bad_dn   = (I_rd_cmd_done && !rd_dn) || (I_wr_cmd_done && !wr_dn);

        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        rd_rem_d      = rd_rem_q;
        wr_addr_d     = wr_addr_q;
        wr_rem_d      = wr_rem_q;
        out_d         = out_q + OW'(rd_hs || wr_hs) - OW'(rd_dn || wr_dn);
        rd_valid_d    = rd_valid_q;
        rd_cmd_addr_d = rd_cmd_addr_q;
        rd_cmd_len_d  = rd_cmd_len_q;
        wr_valid_d    = wr_valid_q;
        wr_cmd_addr_d = wr_cmd_addr_q;
        wr_cmd_len_d  = wr_cmd_len_q;
        err_d         = err_q || bad_dn;
`ifdef ACCEL_JOB_TIMEOUT_EN
        to_cnt_d      = '0;
`endif

        if (rd_hs) begin
            rd_addr_d = rd_addr_q + C_ADDR_WIDTH'(rd_cmd_len_q);
            rd_rem_d  = rd_rem_q - rd_cmd_len_q;
        end
        if (wr_hs) begin
            wr_addr_d = wr_addr_q + C_ADDR_WIDTH'(wr_cmd_len_q);
            wr_rem_d  = wr_rem_q - wr_cmd_len_q;
        end

        case (state_q)
            IDLE: if (I_start) state_d = LOAD;
            LOAD: begin
                rd_addr_d = I_ddr_rd_addr;
                rd_rem_d  = I_in_data_bytes;
                wr_addr_d = I_ddr_wr_addr;
                wr_rem_d  = I_out_data_bytes;
                out_d     = '0;
                err_d     = 1'b0;
                if (I_in_data_bytes != 32'd0)       state_d = RD_ISSUE;
                else if (I_out_data_bytes != 32'd0) state_d = WR_ISSUE;
                else                                state_d = DONE;
            end
            RD_ISSUE: if (rd_hs && rd_rem_d == 32'd0) state_d = RD_WAIT;
            RD_WAIT:  if (out_q == '0) state_d = (wr_rem_q != 32'd0) ? WR_ISSUE : DONE;
            WR_ISSUE: if (wr_hs && wr_rem_d == 32'd0) state_d = WR_WAIT;
            WR_WAIT:  if (out_q == '0) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

`ifdef ACCEL_JOB_TIMEOUT_EN
        if (state_q == RD_WAIT || state_q == WR_WAIT) begin
            if (rd_dn || wr_dn) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == 24'hFF_FFFF) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                to_cnt_d = to_cnt_q + 24'd1;
            end
        end
`endif

        // Commands are built from next-cycle counters so the first one leaves LOAD registered.
        if (!(rd_valid_q && !I_rd_cmd_ready)) begin
            rd_valid_d    = (state_d == RD_ISSUE) && (rd_rem_d != 32'd0) &&
                            (out_d < OW'(C_MAX_OUTSTANDING));
            rd_cmd_addr_d = rd_addr_d;
            rd_cmd_len_d  = cmd_len(rd_addr_d[BB_LOG2-1:0], rd_rem_d);
        end
        if (!(wr_valid_q && !I_wr_cmd_ready)) begin
            wr_valid_d    = (state_d == WR_ISSUE) && (wr_rem_d != 32'd0) &&
                            (out_d < OW'(C_MAX_OUTSTANDING));
            wr_cmd_addr_d = wr_addr_d;
            wr_cmd_len_d  = cmd_len(wr_addr_d[BB_LOG2-1:0], wr_rem_d);
        end

        start_done_d = (state_d == LOAD);
        ap_ready_d   = (state_d == IDLE);
        ap_done_d    = (state_q == DONE);
    end

    always_ff @(posedge I_aclk or posedge I_arst) begin
        if (I_arst) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            rd_rem_q      <= '0;
            wr_addr_q     <= '0;
            wr_rem_q      <= '0;
            out_q         <= '0;
            rd_valid_q    <= 1'b0;
            rd_cmd_addr_q <= '0;
            rd_cmd_len_q  <= '0;
            wr_valid_q    <= 1'b0;
            wr_cmd_addr_q <= '0;
            wr_cmd_len_q  <= '0;
            start_done_q  <= 1'b0;
            ap_ready_q    <= 1'b1;
            ap_done_q     <= 1'b0;
            err_q         <= 1'b0;
`ifdef ACCEL_JOB_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            rd_rem_q      <= rd_rem_d;
            wr_addr_q     <= wr_addr_d;
            wr_rem_q      <= wr_rem_d;
            out_q         <= out_d;
            rd_valid_q    <= rd_valid_d;
            rd_cmd_addr_q <= rd_cmd_addr_d;
            rd_cmd_len_q  <= rd_cmd_len_d;
            wr_valid_q    <= wr_valid_d;
            wr_cmd_addr_q <= wr_cmd_addr_d;
            wr_cmd_len_q  <= wr_cmd_len_d;
            start_done_q  <= start_done_d;
            ap_ready_q    <= ap_ready_d;
            ap_done_q     <= ap_done_d;
            err_q         <= err_d;
`ifdef ACCEL_JOB_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign O_ap_start_done = start_done_q;
    assign O_ap_ready      = ap_ready_q;
    assign O_ap_done       = ap_done_q;
    assign O_rd_cmd_valid  = rd_valid_q;
    assign O_rd_cmd_addr   = rd_cmd_addr_q;
    assign O_rd_cmd_len    = rd_cmd_len_q;
    assign O_wr_cmd_valid  = wr_valid_q;
    assign O_wr_cmd_addr   = wr_cmd_addr_q;
    assign O_wr_cmd_len    = wr_cmd_len_q;
    assign O_err           = err_q;

endmodule

// File: tb/tb_accel_job_ctrl.sv
// Directed bench for accel_job_ctrl: splitting, outstanding limit, errors, reset.
module tb_accel_job_ctrl;

    logic        I_aclk = 1'b0;
    logic        I_arst, I_start;
    logic [31:0] I_ddr_rd_addr, I_ddr_wr_addr, I_in_data_bytes, I_out_data_bytes;
    logic        O_ap_start_done, O_ap_ready, O_ap_done;
    logic        O_rd_cmd_valid, I_rd_cmd_ready, I_rd_cmd_done;
    logic [31:0] O_rd_cmd_addr, O_rd_cmd_len;
    logic        O_wr_cmd_valid, I_wr_cmd_ready, I_wr_cmd_done;
    logic [31:0] O_wr_cmd_addr, O_wr_cmd_len;
    logic        O_err;

    accel_job_ctrl dut (
        .I_aclk(I_aclk), .I_arst(I_arst), .I_start(I_start),
        .I_ddr_rd_addr(I_ddr_rd_addr), .I_ddr_wr_addr(I_ddr_wr_addr),
        .I_in_data_bytes(I_in_data_bytes), .I_out_data_bytes(I_out_data_bytes),
        .O_ap_start_done(O_ap_start_done), .O_ap_ready(O_ap_ready), .O_ap_done(O_ap_done),
        .O_rd_cmd_valid(O_rd_cmd_valid), .I_rd_cmd_ready(I_rd_cmd_ready),
        .O_rd_cmd_addr(O_rd_cmd_addr), .O_rd_cmd_len(O_rd_cmd_len), .I_rd_cmd_done(I_rd_cmd_done),
        .O_wr_cmd_valid(O_wr_cmd_valid), .I_wr_cmd_ready(I_wr_cmd_ready),
        .O_wr_cmd_addr(O_wr_cmd_addr), .O_wr_cmd_len(O_wr_cmd_len), .I_wr_cmd_done(I_wr_cmd_done),
        .O_err(O_err)
    );

    always #5 I_aclk = ~I_aclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake recorder, sampled mid-cycle.
    logic [31:0] rd_a[$], rd_l[$], wr_a[$], wr_l[$];
    int ovl = 0;
    int done_cnt = 0;
    always @(negedge I_aclk) begin
        if (O_rd_cmd_valid && I_rd_cmd_ready) begin rd_a.push_back(O_rd_cmd_addr); rd_l.push_back(O_rd_cmd_len); end
        if (O_wr_cmd_valid && I_wr_cmd_ready) begin wr_a.push_back(O_wr_cmd_addr); wr_l.push_back(O_wr_cmd_len); end
        if (O_rd_cmd_valid && O_wr_cmd_valid) ovl++;
        if (O_ap_done) done_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge I_aclk); #1; end
    endtask

    task automatic start_job(input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] inb, input logic [31:0] outb);
        I_ddr_rd_addr = ra; I_ddr_wr_addr = wa;
        I_in_data_bytes = inb; I_out_data_bytes = outb;
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int b;
        b = done_cnt;
        for (int i = 0; i < limit && done_cnt == b; i++) tick();
        chk(tag, 64'(done_cnt - b), 64'd1);
    endtask

    int rb, wb, db;

    initial begin
        I_arst = 1'b1; I_start = 1'b0;
        I_ddr_rd_addr = '0; I_ddr_wr_addr = '0; I_in_data_bytes = '0; I_out_data_bytes = '0;
        I_rd_cmd_ready = 1'b0; I_rd_cmd_done = 1'b0; I_wr_cmd_ready = 1'b0; I_wr_cmd_done = 1'b0;
        tick(2);
        chk("rst_ready", 64'(O_ap_ready), 64'd1);
        chk("rst_sdone", 64'(O_ap_start_done), 64'd0);
        chk("rst_done", 64'(O_ap_done), 64'd0);
        chk("rst_rdv", 64'(O_rd_cmd_valid), 64'd0);
        chk("rst_wrv", 64'(O_wr_cmd_valid), 64'd0);
        chk("rst_err", 64'(O_err), 64'd0);
        I_arst = 1'b0;
        tick();

        // Empty job: start_done in LOAD, done two cycles later.
        start_job(32'h0, 32'h0, 32'h0, 32'h0);
        chk("z_sdone", 64'(O_ap_start_done), 64'd1);
        chk("z_ready", 64'(O_ap_ready), 64'd0);
        tick();
        chk("z_done_early", 64'(O_ap_done), 64'd0);
        chk("z_rdv", 64'(O_rd_cmd_valid | O_wr_cmd_valid), 64'd0);
        tick();
        chk("z_done", 64'(O_ap_done), 64'd1);
        chk("z_ready2", 64'(O_ap_ready), 64'd1);
        tick();
        chk("z_done_pulse", 64'(O_ap_done), 64'd0);

        // Unaligned read split across burst boundaries.
        I_rd_cmd_ready = 1'b1; I_wr_cmd_ready = 1'b1;
        rb = rd_a.size();
        start_job(32'h1000_0F00, 32'h0, 32'h1800, 32'h0);
        tick();
        chk("s_lat2", 64'(O_rd_cmd_valid), 64'd1);
        tick(6);
        chk("s_cnt", 64'(rd_a.size() - rb), 64'd3);
        if (rd_a.size() - rb == 3) begin
            chk("s_a0", 64'(rd_a[rb]),   64'h1000_0F00); chk("s_l0", 64'(rd_l[rb]),   64'h100);
            chk("s_a1", 64'(rd_a[rb+1]), 64'h1000_1000); chk("s_l1", 64'(rd_l[rb+1]), 64'h1000);
            chk("s_a2", 64'(rd_a[rb+2]), 64'h1000_2000); chk("s_l2", 64'(rd_l[rb+2]), 64'h700);
        end
        chk("s_idle_v", 64'(O_rd_cmd_valid), 64'd0);
        I_rd_cmd_done = 1'b1; tick(3); I_rd_cmd_done = 1'b0;
        wait_done("s_done", 20);
        chk("s_err", 64'(O_err), 64'd0);

        // Outstanding limit, then a boundary-split write phase.
        rb = rd_a.size(); wb = wr_a.size();
        start_job(32'h2000_0000, 32'h3000_0FF0, 32'h5000, 32'h20);
        tick(15);
        chk("o_cnt4", 64'(rd_a.size() - rb), 64'd4);
        chk("o_vlow", 64'(O_rd_cmd_valid), 64'd0);
        I_rd_cmd_done = 1'b1; tick(); I_rd_cmd_done = 1'b0;
        tick(3);
        chk("o_cnt5", 64'(rd_a.size() - rb), 64'd5);
        if (rd_a.size() - rb == 5) chk("o_a4", 64'(rd_a[rb+4]), 64'h2000_4000);
        chk("o_no_wr", 64'(O_wr_cmd_valid), 64'd0);
        I_rd_cmd_done = 1'b1; tick(4); I_rd_cmd_done = 1'b0;
        tick(6);
        chk("w_cnt", 64'(wr_a.size() - wb), 64'd2);
        if (wr_a.size() - wb == 2) begin
            chk("w_a0", 64'(wr_a[wb]),   64'h3000_0FF0); chk("w_l0", 64'(wr_l[wb]),   64'h10);
            chk("w_a1", 64'(wr_a[wb+1]), 64'h3000_1000); chk("w_l1", 64'(wr_l[wb+1]), 64'h10);
        end
        I_wr_cmd_done = 1'b1; tick(2); I_wr_cmd_done = 1'b0;
        wait_done("w_done", 20);
        chk("w_err", 64'(O_err), 64'd0);
        chk("ovl", 64'(ovl), 64'd0);

        // Handshake coinciding with done at outstanding=2 leaves it at 2.
        I_rd_cmd_ready = 1'b0;
        rb = rd_a.size();
        start_job(32'h4000_0000, 32'h0, 32'h8000, 32'h0);
        tick();
        I_rd_cmd_ready = 1'b1; tick(2);
        I_rd_cmd_done = 1'b1; tick(); I_rd_cmd_done = 1'b0;
        tick(8);
        chk("c_cnt", 64'(rd_a.size() - rb), 64'd5);
        chk("c_vlow", 64'(O_rd_cmd_valid), 64'd0);
        I_arst = 1'b1; #2 I_arst = 1'b0;
        tick();

        // Spurious done in IDLE is sticky until the next accepted start.
        I_rd_cmd_done = 1'b1; tick(); I_rd_cmd_done = 1'b0;
        chk("e_set", 64'(O_err), 64'd1);
        tick(2);
        chk("e_sticky", 64'(O_err), 64'd1);
        start_job(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("e_clr", 64'(O_err), 64'd0);
        tick(3);

        // Reset while waiting for completions aborts the job silently.
        start_job(32'h5000_0000, 32'h0, 32'h100, 32'h0);
        tick(4);
        db = done_cnt;
        I_arst = 1'b1; #1;
        chk("r_ready", 64'(O_ap_ready), 64'd1);
        chk("r_vlow", 64'(O_rd_cmd_valid), 64'd0);
        #2 I_arst = 1'b0;
        tick(5);
        chk("r_nodone", 64'(done_cnt - db), 64'd0);
        chk("r_ready2", 64'(O_ap_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/accel_job_ctrl.md
ACCEL_JOB_CTRL -- requirements
Module: accel_job_ctrl

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32, meaning DDR byte-address width.
REQ-002 SHALL have parameter C_BURST_BYTES, default 4096, meaning the power-of-two maximum command size and alignment boundary.
REQ-003 SHALL have parameter C_MAX_OUTSTANDING, default 4, meaning the maximum number of issued commands not yet completed, per phase.
REQ-004 SHALL have ports, in order:
- I_aclk  in  1  clock; one clock.
- I_arst  in  1  reset; asynchronous, active-high.
- I_start  in  1  job start level.
- I_ddr_rd_addr  in  C_ADDR_WIDTH  input buffer base.
- I_ddr_wr_addr  in  C_ADDR_WIDTH  output buffer base.
- I_in_data_bytes  in  32  bytes to read.
- I_out_data_bytes  in  32  bytes to write.
- O_ap_start_done  out  1  one-cycle pulse: start accepted.
- O_ap_ready  out  1  idle, new job accepted.
- O_ap_done  out  1  one-cycle pulse: job finished.
- O_rd_cmd_valid / I_rd_cmd_ready  out/in  1  read-command handshake.
- O_rd_cmd_addr  out  C_ADDR_WIDTH  read-command address.
- O_rd_cmd_len  out  32  read-command length in bytes, nonzero.
- I_rd_cmd_done  in  1  one-cycle pulse per completed read command.
- O_wr_cmd_valid / I_wr_cmd_ready / O_wr_cmd_addr / O_wr_cmd_len / I_wr_cmd_done  as the read set, for writes.
- O_err  out  1  sticky error flag, cleared only on next accepted start.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
REQ-006 IDLE: O_ap_ready=1; I_start=1 -> LOAD; O_ap_start_done pulses in the LOAD cycle; I_start is ignored in every other state.
REQ-007 LOAD SHALL latch addresses/byte counts into internal rd_addr, rd_rem, wr_addr, wr_rem and clear O_err; next state is RD_ISSUE if rd_rem!=0, else WR_ISSUE if wr_rem!=0, else DONE.
REQ-008 Command length SHALL be min(rem, C_BURST_BYTES - (addr mod C_BURST_BYTES)); no command crosses a C_BURST_BYTES boundary.
REQ-009 O_*_cmd_valid/addr/len SHALL be registered and held stable until ready; on handshake addr+=len, rem-=len, outstanding+=1.
REQ-010 No valid SHALL be asserted while outstanding==C_MAX_OUTSTANDING.
REQ-011 A done pulse SHALL decrement outstanding; a simultaneous handshake and done leaves it unchanged; a done with outstanding==0 sets O_err and is otherwise ignored.
REQ-012 RD_ISSUE -> RD_WAIT when rem reaches 0 on a handshake; RD_WAIT -> WR_ISSUE (or DONE if wr_rem==0) when outstanding==0.
REQ-013 WR_ISSUE/WR_WAIT SHALL mirror REQ-012; WR_WAIT -> DONE when outstanding==0.
REQ-014 DONE SHALL pulse O_ap_done for exactly one cycle and return to IDLE.
REQ-015 Read and write phases SHALL never overlap; start-to-first-valid latency is 2 cycles.

Reset
REQ-016 I_arst SHALL asynchronously force IDLE, clear all counters and outputs to 0 except O_ap_ready=1; mid-job reset drops outstanding commands without waiting.

Configuration
REQ-017 Macro ACCEL_JOB_TIMEOUT_EN: when defined, a 24-bit counter runs in RD_WAIT/WR_WAIT, is cleared on each done pulse, and on reaching 2^24-1 sets O_err and goes to DONE; when undefined, wait states never time out and the counter is absent.

Verification
REQ-018 in=0x1800, rd_addr=0x1000_0F00, ready=1 -> read commands (0x1000_0F00,0x100),(0x1000_1000,0x1000),(0x1000_2000,0x700).
REQ-019 in=0x5000, rd_addr aligned, done withheld -> exactly 4 handshakes and valid low until the first done pulse.
REQ-020 in=0, out=0 -> O_ap_start_done then O_ap_done two cycles later, no command valid.
REQ-021 Handshake and done in the same cycle with outstanding=2 -> stays 2; a spurious done in IDLE sets O_err=1, cleared by the next start.
REQ-022 I_arst pulse during RD_WAIT -> IDLE immediately, O_ap_ready=1, no O_ap_done; with ACCEL_JOB_TIMEOUT_EN, done withheld -> O_err=1 and O_ap_done after 2^24-1 cycles.
